md5_stream_core: RTL and testbench

Parametrised, multi-block successor to the single-block MD5 unit in the crypto accelerator path of the custom-instruction datapath. It accepts 512-bit pre-padded message blocks over a valid/ready handshake and chains the MD5 state across blocks. It computes a configurable number of rounds per cycle, and returns the 128-bit digest over a second valid/ready handshake. Padding and length encoding remain the caller's (software or upstream) job.

---
 rtl/md5_pkg.sv | 82 ++++++++
 rtl/md5_step.sv | 42 ++++
 rtl/md5_stream_core.sv | 181 ++++++++++++++++++
 tb/tb_md5_stream_core.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// md5_pkg: shared MD5 constants and helpers.
//   - md5_state_e  : control FSM states
//   - md5_words_t  : packed {a, b, c, d} working/chain word set
//   - IvWords      : MD5 initialisation vector
//   - KTable       : 64-entry additive constant table
//   - md5_shift    : per-step left-rotate amount
//   - md5_msg_index: per-step message word index
//   - md5_bswap32  : byte reversal of a 32-bit word
package md5_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFinal,
        StDone
    } md5_state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } md5_words_t;

    localparam logic [31:0] IvA = 32'h67452301;
    localparam logic [31:0] IvB = 32'hefcdab89;
    localparam logic [31:0] IvC = 32'h98badcfe;
    localparam logic [31:0] IvD = 32'h10325476;

    localparam md5_words_t IvWords = {IvA, IvB, IvC, IvD};

    localparam logic [31:0] KTable [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Rotate amounts repeat every four steps within a round, so the table
    // is indexed by {round, step mod 4}.
    localparam logic [4:0] ShiftTable [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [4:0] md5_shift(input logic [5:0] step);
        return ShiftTable[{step[5:4], step[1:0]}];
    endfunction

    // Message word schedule; 4-bit arithmetic gives the mod-16 for free.
    function automatic logic [3:0] md5_msg_index(input logic [5:0] step);
        logic [3:0] s;
        logic [3:0] idx;
        s = step[3:0];
        unique case (step[5:4])
            2'd0:    idx = s;
            2'd1:    idx = s * 4'd5 + 4'd1;
            2'd2:    idx = s * 4'd3 + 4'd5;
            default: idx = s * 4'd7;
        endcase
        return idx;
    endfunction

    function automatic logic [31:0] md5_bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/md5_step.sv
// md5_step: one purely combinational MD5 step.
// Ports:
//   a, b, c, d      in  32  current working words
//   step            in  6   step index 0..63 (selects function, K, rotate)
//   word            in  32  message word already selected for this step
//   a_next..d_next  out 32  working words after the step
module md5_step
    import md5_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [5:0]  step,
    input  logic [31:0] word,
    output logic [31:0] a_next,
    output logic [31:0] b_next,
    output logic [31:0] c_next,
    output logic [31:0] d_next
);

    logic [31:0] f;
    logic [31:0] sum;
    logic [63:0] rot_dbl;

    always_comb begin
        unique case (step[5:4])
            2'd0:    f = (b & c) | (~b & d);
            2'd1:    f = (d & b) | (~d & c);
            2'd2:    f = b ^ c ^ d;
            default: f = c ^ (b | ~d);
        endcase
        sum     = a + f + KTable[step] + word;
        // Upper half of {sum, sum} << n is rotl(sum, n).
        rot_dbl = {sum, sum} << md5_shift(step);
        a_next  = d;
        b_next  = b + rot_dbl[63:32];
        c_next  = b;
        d_next  = c;
    end

endmodule

// File: rtl/md5_stream_core.sv
// md5_stream_core: multi-block MD5 engine with chained state.
// Accepts pre-padded 512-bit blocks, runs ROUNDS_PER_CYCLE steps per clock
// and presents the digest after a block flagged last.
// Parameter:
//   ROUNDS_PER_CYCLE  steps per clock; 1, 2, 4, 8 or 16
// Ports:
//   clock, reset            sole clock; synchronous active-high reset
//   in_valid/in_ready       block handshake (ready only while idle)
//   in_block[511:0]         word i at [32i+31:32i]
//   in_first, in_last       restart chain from IV / present digest after
//   out_valid/out_ready     digest handshake
//   out_digest[127:0]       final digest, held while out_valid
//   busy                    engine not idle
// Build option:
//   MD5_DIGEST_BSWAP_EN     defined: canonical byte order (first digest byte
//                           at [127:120]); otherwise {D, C, B, A}.
module md5_stream_core
    import md5_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_digest,
    output logic         busy
);

    localparam int unsigned R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : gen_bad_rounds
        $error("md5_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    md5_state_e  state_q, state_d;
    logic [511:0] msg_q;
    logic         last_q;
    logic [5:0]   step_q;
    md5_words_t   work_q;
    md5_words_t   chain_q;
    md5_words_t   run_out;
    md5_words_t   chain_sum;
    logic [127:0] digest_q;
    logic [127:0] digest_d;
    logic         step_done;

    // Chain of R combinational steps; the last stage feeds the working regs.
    for (genvar i = 0; i < R; i++) begin : gen_steps
        logic [31:0] cur_a, cur_b, cur_c, cur_d;
        logic [31:0] nxt_a, nxt_b, nxt_c, nxt_d;
        logic [5:0]  idx;
        logic [3:0]  widx;

        if (i == 0) begin : gen_head
            assign {cur_a, cur_b, cur_c, cur_d} = work_q;
        end else begin : gen_link
            assign cur_a = gen_steps[i-1].nxt_a;
            assign cur_b = gen_steps[i-1].nxt_b;
            assign cur_c = gen_steps[i-1].nxt_c;
            assign cur_d = gen_steps[i-1].nxt_d;
        end

        assign idx  = step_q + 6'(i);
        assign widx = md5_msg_index(idx);

        md5_step u_step (
            .a      (cur_a),
            .b      (cur_b),
            .c      (cur_c),
            .d      (cur_d),
            .step   (idx),
            .word   (msg_q[{widx, 5'd0} +: 32]),
            .a_next (nxt_a),
            .b_next (nxt_b),
            .c_next (nxt_c),
            .d_next (nxt_d)
        );

        if (i == R - 1) begin : gen_tail
            assign run_out = {nxt_a, nxt_b, nxt_c, nxt_d};
        end
    end

    assign step_done = ({1'b0, step_q} + 7'(R)) == 7'd64;

    always_comb begin
        chain_sum.a = chain_q.a + work_q.a;
        chain_sum.b = chain_q.b + work_q.b;
        chain_sum.c = chain_q.c + work_q.c;
        chain_sum.d = chain_q.d + work_q.d;
    end

`ifdef MD5_DIGEST_BSWAP_EN
    assign digest_d = {md5_bswap32(chain_sum.a), md5_bswap32(chain_sum.b),
                       md5_bswap32(chain_sum.c), md5_bswap32(chain_sum.d)};
`else
    assign digest_d = {chain_sum.d, chain_sum.c, chain_sum.b, chain_sum.a};
`endif

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (step_done) state_d = StFinal;
            StFinal: state_d = last_q ? StDone : StIdle;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; in_ready is masked by reset so it reads 0 during reset.
    always_comb begin
        in_ready  = (state_q == StIdle) && !reset;
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

    assign out_digest = digest_q;

    // Datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            msg_q    <= '0;
            last_q   <= 1'b0;
            step_q   <= '0;
            work_q   <= IvWords;
            chain_q  <= IvWords;
            digest_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        msg_q  <= in_block;
                        last_q <= in_last;
                        step_q <= '0;
                        if (in_first) begin
                            work_q  <= IvWords;
                            chain_q <= IvWords;
                        end else begin
                            work_q <= chain_q;
                        end
                    end
                end
                StRun: begin
                    work_q <= run_out;
                    step_q <= step_q + 6'(R);
                end
                StFinal: begin
                    chain_q <= chain_sum;
                    if (last_q) begin
                        digest_q <= digest_d;
                    end
                end
                StDone: begin
                    // Next message starts from the IV even without in_first.
                    if (out_ready) begin
                        chain_q <= IvWords;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_stream_core.sv
module tb_md5_stream_core;

    localparam logic [127:0] DgEmpty = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] DgAbc   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] Dg1234  = 128'h57edf4a22be3c955ac49da2e2107b67a;
    localparam logic [127:0] DgFox   = 128'h9e107d9d372bb6826bd81d3542a419d6;

    localparam int unsigned SweepR [4] = '{1, 2, 8, 16};

    logic         clock = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         in_first;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_digest;
    logic         busy;

    logic         sw_valid;
    logic [511:0] sw_block;
    logic         sw_ready [4];
    logic         sw_out_valid [4];
    logic [127:0] sw_digest [4];
    logic         sw_busy [4];

    int checks = 0;
    int errors = 0;

    string s_abc = "abc";
    string s_fox = "The quick brown fox jumps over the lazy dog";
    string s_1234;

    always #5 clock = ~clock;

    md5_stream_core #(.ROUNDS_PER_CYCLE(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .in_first   (in_first),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digest (out_digest),
        .busy       (busy)
    );

    for (genvar g = 0; g < 4; g++) begin : gen_sweep
        md5_stream_core #(.ROUNDS_PER_CYCLE(SweepR[g])) u_dut (
            .clock      (clock),
            .reset      (reset),
            .in_valid   (sw_valid),
            .in_ready   (sw_ready[g]),
            .in_block   (sw_block),
            .in_first   (1'b1),
            .in_last    (1'b1),
            .out_valid  (sw_out_valid[g]),
            .out_ready  (1'b1),
            .out_digest (sw_digest[g]),
            .busy       (sw_busy[g])
        );
    end

    // Standard MD5 padding of a string of at most 119 bytes; returns block blk.
    function automatic logic [511:0] make_block(input string s, input int blk);
        int len;
        int nblk;
        logic [63:0] bits;
        logic [511:0] r;
        len  = s.len();
        nblk = (len + 9 <= 64) ? 1 : 2;
        bits = 64'(len) * 64'd8;
        r    = '0;
        for (int j = 0; j < 64; j++) begin
            int p;
            logic [7:0] b;
            p = blk * 64 + j;
            b = 8'h00;
            if (p < len) b = s[p];
            else if (p == len) b = 8'h80;
            else if (blk == nblk - 1 && j >= 56) b = bits[8*(j-56) +: 8];
            r[8*j +: 8] = b;
        end
        return r;
    endfunction

    // Canonical hex -> the packing this build presents.
    function automatic logic [127:0] exp_dg(input logic [127:0] canon);
`ifdef MD5_DIGEST_BSWAP_EN
        return canon;
`else
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = canon[8*(15-i) +: 8];
        return r;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns the number of cycles spent waiting for in_ready.
    task automatic send_block(input logic [511:0] blk, input logic first, input logic last,
                              output int waited);
        in_block = blk;
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_digest(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_block  = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        sw_valid  = 1'b0;
        sw_block  = '0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b required 0", busy);
        end
        checks++;
        if (out_digest !== 128'h0) begin
            errors++; $display("FAIL reset_digest: got %h required 0", out_digest);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready);
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (sw_ready[g] !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_sweep_ready[%0d]: got %b required 1", g, sw_ready[g]);
            end
        end
    endtask

    task automatic test_empty();
        int w;
        int c;
        send_block(make_block("", 0), 1'b1, 1'b1, w);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL empty_busy: got %b required 1", busy);
        end
        wait_digest(c);
        checks++;
        if (c !== 17) begin
            errors++; $display("FAIL empty_latency: got %0d required 17", c);
        end
        checks++;
        if (out_digest !== exp_dg(DgEmpty)) begin
            errors++;
            $display("FAIL empty_digest: got %h required %h", out_digest, exp_dg(DgEmpty));
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_release: out_valid=%b in_ready=%b required 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_abc_sweep();
        int w;
        int c;
        int lat [4];
        logic [127:0] dg [4];
        send_block(make_block(s_abc, 0), 1'b1, 1'b1, w);
        wait_digest(c);
        checks++;
        if (c !== 17) begin
            errors++; $display("FAIL abc_r4_latency: got %0d required 17", c);
        end
        checks++;
        if (out_digest !== exp_dg(DgAbc)) begin
            errors++;
            $display("FAIL abc_r4_digest: got %h required %h", out_digest, exp_dg(DgAbc));
        end
        tick();

        for (int g = 0; g < 4; g++) begin
            lat[g] = 0;
            dg[g]  = '0;
        end
        sw_block = make_block(s_abc, 0);
        sw_valid = 1'b1;
        tick();
        sw_valid = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            tick();
            for (int g = 0; g < 4; g++) begin
                if (sw_out_valid[g] && lat[g] == 0) begin
                    lat[g] = cyc;
                    dg[g]  = sw_digest[g];
                end
            end
        end
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (lat[g] !== int'(64 / SweepR[g] + 1)) begin
                errors++;
                $display("FAIL abc_r%0d_latency: got %0d required %0d",
                         SweepR[g], lat[g], 64 / SweepR[g] + 1);
            end
            checks++;
            if (dg[g] !== exp_dg(DgAbc)) begin
                errors++;
                $display("FAIL abc_r%0d_digest: got %h required %h",
                         SweepR[g], dg[g], exp_dg(DgAbc));
            end
        end
    endtask

    task automatic test_hold_output();
        int w;
        int c;
        int bad;
        out_ready = 1'b0;
        send_block(make_block(s_1234, 0), 1'b1, 1'b0, w);
        send_block(make_block(s_1234, 1), 1'b0, 1'b1, w);
        checks++;
        if (w !== 17) begin
            errors++; $display("FAIL two_block_ready_return: got %0d required 17", w);
        end
        wait_digest(c);
        checks++;
        if (c !== 17) begin
            errors++; $display("FAIL two_block_latency: got %0d required 17", c);
        end
        checks++;
        if (out_digest !== exp_dg(Dg1234)) begin
            errors++;
            $display("FAIL two_block_digest: got %h required %h", out_digest, exp_dg(Dg1234));
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b1 || out_digest !== exp_dg(Dg1234) || in_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL hold_stable: unstable cycles %0d required 0", bad);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b required 0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        int c;
        send_block(make_block(s_abc, 0), 1'b1, 1'b1, w);
        wait_digest(c);
        checks++;
        if (out_digest !== exp_dg(DgAbc)) begin
            errors++;
            $display("FAIL b2b_abc_digest: got %h required %h", out_digest, exp_dg(DgAbc));
        end
        send_block(make_block(s_fox, 0), 1'b1, 1'b1, w);
        wait_digest(c);
        checks++;
        if (c !== 17) begin
            errors++; $display("FAIL b2b_fox_latency: got %0d required 17", c);
        end
        checks++;
        if (out_digest !== exp_dg(DgFox)) begin
            errors++;
            $display("FAIL b2b_fox_digest: got %h required %h", out_digest, exp_dg(DgFox));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int w;
        int c;
        int seen;
        send_block(make_block(s_1234, 0), 1'b1, 1'b0, w);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midreset_busy_before: got %b required 1", busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_idle: busy=%b in_ready=%b required 0/1", busy, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL midreset_no_output: out_valid cycles %0d required 0", seen);
        end
        send_block(make_block(s_1234, 0), 1'b1, 1'b0, w);
        send_block(make_block(s_1234, 1), 1'b0, 1'b1, w);
        wait_digest(c);
        checks++;
        if (out_digest !== exp_dg(Dg1234)) begin
            errors++;
            $display("FAIL midreset_resend_digest: got %h required %h",
                     out_digest, exp_dg(Dg1234));
        end
        tick();
    endtask

    task automatic test_restart();
        int w;
        int c;
        send_block(make_block(s_1234, 0), 1'b1, 1'b0, w);
        send_block(make_block(s_abc, 0), 1'b1, 1'b1, w);
        wait_digest(c);
        checks++;
        if (out_digest !== exp_dg(DgAbc)) begin
            errors++;
            $display("FAIL restart_digest: got %h required %h", out_digest, exp_dg(DgAbc));
        end
        tick();
        // After a completed message the chain is the IV even without in_first.
        send_block(make_block(s_abc, 0), 1'b0, 1'b1, w);
        wait_digest(c);
        checks++;
        if (c !== 17 || out_digest !== exp_dg(DgAbc)) begin
            errors++;
            $display("FAIL nofirst_digest: got %h after %0d required %h after 17",
                     out_digest, c, exp_dg(DgAbc));
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_1234 = "";
        for (int i = 0; i < 8; i++) s_1234 = {s_1234, "1234567890"};
        test_reset();
        test_empty();
        test_abc_sweep();
        test_hold_output();
        test_back_to_back();
        test_reset_mid();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
